// File: rtl/jt5205_interp_sched_pkg.sv
// Shared definitions for the jt5205 interpolation scheduler.
// Contents:
//   DEF_CHANNELS / DEF_DW : default voice count and sample width
//   wrap_inc()            : modular increment used for the round-robin pointer
package jt5205_interp_sched_pkg;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_DW       = 12;

    // Increment v modulo n, without a divider.
    function automatic int wrap_inc(input int v, input int n);
        int r;
        r = v + 1;
        if (r >= n) begin
            r = 0;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/jt5205_interp_sched_arb.sv
// Round-robin arbiter for the interpolation scheduler.
// The grant is the first pending channel found when scanning from ptr
// upwards, modulo CHANNELS. After each grant the pointer moves past the
// winner. It stays put while nothing is pending.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (ptr -> 0)
//   pend       : per-channel pending flags
//   grant      : index of the granted channel (meaningful when valid=1)
//   valid      : a channel is granted this cycle
module jt5205_interp_sched_arb
    import jt5205_interp_sched_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int PW       = $clog2(DEF_CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] pend,
    output logic [PW-1:0]       grant,
    output logic                valid
);

    localparam logic [PW:0] NCH = (PW+1)'(CHANNELS);

    logic [PW-1:0] ptr_r;
    logic [PW:0]   sum_s;
    logic [PW-1:0] idx_s;
    logic          hit_s;

    // Scan the pending flags starting at ptr and keep the first hit.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        sum_s = '0;
        idx_s = '0;
        hit_s = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            sum_s = {1'b0, ptr_r} + (PW+1)'(k);
            idx_s = (sum_s >= NCH) ? PW'(sum_s - NCH) : PW'(sum_s);
            hit_s = !valid && pend[idx_s];
            grant = hit_s ? idx_s : grant;
            valid = valid | hit_s;
        end
    end

    // Move the pointer past the granted channel and hold it while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (valid) begin
            ptr_r <= PW'(wrap_inc(int'(grant), CHANNELS));
        end
    end

endmodule

// File: rtl/jt5205_interp_sched.sv
// Time-multiplexed 2x interpolation scheduler for several jt5205 voices.
// Each voice strobes req with a sample. The sample is buffered and marked
// pending. A round-robin arbiter then picks one pending voice per cycle for
// the shared datapath, which computes (last>>>1)+(din>>>1).
// Pipeline:
//   E1 : grant taken, operands latched into stage 1
//   E2 : dout/last written, done pulsed
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-channel one-cycle sample strobe
//   din        : packed samples, channel i at [i*DW +: DW]
//   dout       : packed interpolated outputs, held between updates
//   done       : one-cycle pulse per channel when its dout slice updates
//   busy       : something pending or in flight
//   ovr        : sticky overrun flags (only with JT5205_SCHED_OVR_EN)
//   ovr_clr    : per-channel clear of ovr (only with JT5205_SCHED_OVR_EN)
// Optional feature macro: JT5205_SCHED_OVR_EN
module jt5205_interp_sched
    import jt5205_interp_sched_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DW       = DEF_DW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CHANNELS-1:0]    req,
    input  logic [CHANNELS*DW-1:0] din,
    output logic [CHANNELS*DW-1:0] dout,
    output logic [CHANNELS-1:0]    done,
    output logic                   busy
`ifdef JT5205_SCHED_OVR_EN
    ,
    output logic [CHANNELS-1:0]    ovr,
    input  logic [CHANNELS-1:0]    ovr_clr
`endif
);

    localparam int PW = $clog2(CHANNELS);

    logic [CHANNELS-1:0]    pend_r;
    logic [DW-1:0]          buf_r  [CHANNELS];
    logic [DW-1:0]          last_r [CHANNELS];
    logic [CHANNELS*DW-1:0] dout_r;
    logic [CHANNELS-1:0]    done_r;

    logic                   s1_v_r;
    logic [PW-1:0]          s1_ch_r;
    logic signed [DW-1:0]   s1_a_r;
    logic signed [DW-1:0]   s1_b_r;

    logic [PW-1:0]          grant_s;
    logic                   gnt_v_s;
    logic [CHANNELS-1:0]    gnt_mask_s;
    logic [DW-1:0]          a_src_s;
    logic signed [DW-1:0]   sum_s;

    jt5205_interp_sched_arb #(
        .CHANNELS (CHANNELS),
        .PW       (PW)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .pend  (pend_r),
        .grant (grant_s),
        .valid (gnt_v_s)
    );

    // One-hot mask of the channel being granted this cycle.
    always_comb begin
        gnt_mask_s          = '0;
        gnt_mask_s[grant_s] = gnt_v_s;
    end

    // A channel can be granted on back-to-back cycles. Its "last" is then
    // still in stage 1, so forward it instead of reading the stale array entry.
    always_comb begin
        a_src_s = last_r[grant_s];
        if (s1_v_r && (s1_ch_r == grant_s)) begin
            a_src_s = s1_b_r;
        end else begin
            a_src_s = last_r[grant_s];
        end
    end

    // Halving both operands first keeps the sum inside DW bits.
    assign sum_s = (s1_a_r >>> 1) + (s1_b_r >>> 1);

    // Capture, pending flags, stage 1 operand latch and stage 2 write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r  <= '0;
            dout_r  <= '0;
            done_r  <= '0;
            s1_v_r  <= 1'b0;
            s1_ch_r <= '0;
            s1_a_r  <= '0;
            s1_b_r  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                buf_r[i]  <= '0;
                last_r[i] <= '0;
            end
        end else begin
            // A new req on the granted channel keeps it pending. The granted
            // op still uses the buffer value from before this edge.
            for (int i = 0; i < CHANNELS; i++) begin
                if (req[i]) begin
                    buf_r[i] <= din[i*DW +: DW];
                end
            end
            pend_r <= req | (pend_r & ~gnt_mask_s);

            s1_v_r  <= gnt_v_s;
            s1_ch_r <= grant_s;
            s1_a_r  <= a_src_s;
            s1_b_r  <= buf_r[grant_s];

            done_r <= '0;
            if (s1_v_r) begin
                dout_r[s1_ch_r*DW +: DW] <= sum_s;
                last_r[s1_ch_r]          <= s1_b_r;
                done_r[s1_ch_r]          <= 1'b1;
            end
        end
    end

    assign dout = dout_r;
    assign done = done_r;
    assign busy = (|pend_r) | s1_v_r;

`ifdef JT5205_SCHED_OVR_EN
    logic [CHANNELS-1:0] ovr_r;
    logic [CHANNELS-1:0] ovr_set_s;

    // Overrun: a new sample lands on a still-pending, ungranted channel.
    assign ovr_set_s = req & pend_r & ~gnt_mask_s;

    // Sticky overrun flags. A set beats a clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_r <= '0;
        end else begin
            ovr_r <= (ovr_r & ~ovr_clr) | ovr_set_s;
        end
    end

    assign ovr = ovr_r;
`endif

endmodule
